// File: rtl/msk_hpc3_rnd_feeder_pkg.sv
// Shared HPC3 definitions: FSM encoding, LFSR geometry and the fresh-randomness
// count d*(d-1) that a column of HPC3 gadgets consumes per cycle.
package msk_hpc3_rnd_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_WARM = 2'd2,
    ST_RUN  = 2'd3
  } fsm_state_t;

  localparam int LFSR_W = 31;
  localparam int TAP_HI = 30;
  localparam int TAP_LO = 27;
  localparam int SEED_W = 32;
  localparam int CNT_W  = 16;

  function automatic int hpc3_rnd_bits(input int shares);
    return shares * (shares - 1);
  endfunction

endpackage

// File: rtl/msk_lfsr31_lane.sv
// One 31-bit Fibonacci LFSR lane (x^31 + x^28 + 1); load wins over step and an
// all-zero load value is replaced by 1 so the lane can never lock up.
module msk_lfsr31_lane
  import msk_hpc3_rnd_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic              out_bit
);

  logic [LFSR_W-1:0] s;

  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
    end else if (load) begin
      s <= (load_val == '0) ? LFSR_W'(1) : load_val;
    end else if (step) begin
      s <= {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
    end
  end

  assign out_bit = s[LFSR_W-1];

endmodule

// File: rtl/msk_hpc3_rnd_feeder.sv
// Fresh-randomness feeder for a column of HPC3 gadgets: seeds d*(d-1) LFSR lanes,
// warms them up, then serves one never-repeated word per rnd handshake.
module msk_hpc3_rnd_feeder
  import msk_hpc3_rnd_feeder_pkg::*;
#(
  parameter int d    = 2,
  parameter int WARM = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SEED_W-1:0]      seed,
  input  logic                   seed_valid,
  output logic                   seed_ready,
  input  logic                   reseed,
  output logic [d*(d-1)-1:0]     rnd,
  output logic                   rnd_valid,
  input  logic                   rnd_ready,
  output logic                   busy,
  output logic [1:0]             state
);

  localparam int NL    = hpc3_rnd_bits(d);
  localparam int IDX_W = (NL > 1) ? $clog2(NL) : 1;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends combinationally on ready, and data is held until taken.
  fsm_state_t        st;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic              seed_ready_q;
  logic              rnd_valid_q;
  logic              busy_q;
  logic [NL-1:0]     lane_bits;
  logic              seed_fire;
  logic              rnd_fire;
  logic              lane_step;
  logic              last_beat;
  logic              unused_seed_msb;

  assign seed_fire       = seed_ready_q & seed_valid;
  assign rnd_fire        = rnd_valid_q & rnd_ready;
  assign lane_step       = (st == ST_WARM) | rnd_fire;
  assign last_beat       = seed_fire && (idx == IDX_W'(NL - 1));
  assign unused_seed_msb = seed[SEED_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= ST_IDLE;
      idx          <= '0;
      cnt          <= '0;
      seed_ready_q <= 1'b0;
      rnd_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (reseed | seed_valid) begin
            st           <= ST_SEED;
            seed_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_SEED: begin
          if (reseed) begin
            idx <= '0;
          end else if (last_beat) begin
            idx          <= '0;
            cnt          <= '0;
            st           <= ST_WARM;
            seed_ready_q <= 1'b0;
          end else if (seed_fire) begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_WARM, ST_RUN: begin
          if (reseed) begin
            st           <= ST_SEED;
            idx          <= '0;
            cnt          <= '0;
            seed_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            rnd_valid_q  <= 1'b0;
          end else if (st == ST_WARM) begin
            // The edge that completes the WARM-th step is the edge that raises rnd_valid.
            if (cnt == CNT_W'(WARM - 1)) begin
              st          <= ST_RUN;
              cnt         <= '0;
              busy_q      <= 1'b0;
              rnd_valid_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NL; k++) begin : g_lane
    msk_lfsr31_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (seed_fire && (idx == IDX_W'(k))),
      .load_val (seed[LFSR_W-1:0]),
      .step     (lane_step),
      .out_bit  (lane_bits[k])
    );
  end

  assign rnd        = rnd_valid_q ? lane_bits : '0;
  assign rnd_valid  = rnd_valid_q;
  assign seed_ready = seed_ready_q;
  assign busy       = busy_q;
  assign state      = st;

endmodule

// File: tb/tb_msk_hpc3_rnd_feeder.sv
// Bench for msk_hpc3_rnd_feeder: a d=2 and a d=3 instance checked against a
// bench-side LFSR model through an expected-word queue.
module tb_msk_hpc3_rnd_feeder;

  localparam int WARM2 = 4;
  localparam int WARM3 = 6;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] seed2, seed3;
  logic        seed_valid2, seed_valid3, seed_ready2, seed_ready3;
  logic        reseed2, reseed3;
  logic [1:0]  rnd2;
  logic [5:0]  rnd3;
  logic        rnd_valid2, rnd_valid3, rnd_ready2, rnd_ready3;
  logic        busy2, busy3;
  logic [1:0]  state2, state3;

  msk_hpc3_rnd_feeder #(.d(2), .WARM(WARM2)) dut2 (
    .clk(clk), .rst(rst), .seed(seed2), .seed_valid(seed_valid2), .seed_ready(seed_ready2),
    .reseed(reseed2), .rnd(rnd2), .rnd_valid(rnd_valid2), .rnd_ready(rnd_ready2),
    .busy(busy2), .state(state2)
  );

  msk_hpc3_rnd_feeder #(.d(3), .WARM(WARM3)) dut3 (
    .clk(clk), .rst(rst), .seed(seed3), .seed_valid(seed_valid3), .seed_ready(seed_ready3),
    .reseed(reseed3), .rnd(rnd3), .rnd_valid(rnd_valid3), .rnd_ready(rnd_ready3),
    .busy(busy3), .state(state3)
  );

  // scoreboard
  logic [5:0]  exp_q[$];
  logic [30:0] mdl[6];
  logic [31:0] seeds[6];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [30:0] fix31(input logic [31:0] s);
    return (s[30:0] == 31'd0) ? 31'd1 : s[30:0];
  endfunction

  function automatic logic [30:0] step31(input logic [30:0] s);
    return {s[29:0], s[30] ^ s[27]};
  endfunction

  function automatic logic cur_valid(input int sel);
    return (sel == 2) ? rnd_valid2 : rnd_valid3;
  endfunction

  function automatic logic [5:0] cur_rnd(input int sel);
    return (sel == 2) ? {4'd0, rnd2} : rnd3;
  endfunction

  task automatic set_ready(input int sel, input logic v);
    if (sel == 2) rnd_ready2 = v;
    else          rnd_ready3 = v;
  endtask

  task automatic model_step(input int nl, input int times);
    for (int t = 0; t < times; t++)
      for (int k = 0; k < nl; k++) mdl[k] = step31(mdl[k]);
  endtask

  task automatic model_push(input int nl, input int nwords);
    for (int w = 0; w < nwords; w++) begin
      logic [5:0] word;
      word = '0;
      for (int k = 0; k < nl; k++) word[k] = mdl[k][30];
      exp_q.push_back(word);
      model_step(nl, 1);
    end
  endtask

  // driver: present one seed beat and hold it until accepted
  task automatic beat(input int sel, input logic [31:0] s);
    int n;
    n = 0;
    if (sel == 2) begin seed2 = s; seed_valid2 = 1'b1; end
    else          begin seed3 = s; seed_valid3 = 1'b1; end
    while (!((sel == 2) ? seed_ready2 : seed_ready3) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("seed_accept_timeout", n, 0);
    @(negedge clk);
    seed_valid2 = 1'b0;
    seed_valid3 = 1'b0;
  endtask

  // count cycles from the last accepted beat to rnd_valid; rnd must read 0 meanwhile
  task automatic warm_wait(input int sel, input int lat);
    int n;
    n = 0;
    while (!cur_valid(sel) && n < 200) begin
      check("rnd_zero_in_warm", cur_rnd(sel), 0);
      check("busy_in_warm", (sel == 2) ? busy2 : busy3, 1);
      @(negedge clk);
      n++;
    end
    check("warm_latency", n, lat);
  endtask

  // consumer: mode 0 = always ready, 1 = random ready; non-taken words must hold
  task automatic consume(input int sel, input int nwords, input int mode);
    int got, cyc;
    got = 0;
    cyc = 0;
    while (got < nwords && cyc < 20 * nwords + 50) begin
      set_ready(sel, (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
      if (exp_q.size() == 0) begin
        check("sb_underflow", exp_q.size(), 1);
        got = nwords;
      end else if (cur_valid(sel) && ((sel == 2) ? rnd_ready2 : rnd_ready3)) begin
        check("rnd_word", cur_rnd(sel), exp_q.pop_front());
        got++;
      end else if (cur_valid(sel)) begin
        check("rnd_hold", cur_rnd(sel), exp_q[0]);
      end
      @(negedge clk);
      cyc++;
    end
    set_ready(sel, 1'b0);
    if (got < nwords) check("consume_timeout", got, nwords);
  endtask

  initial begin
    rst = 1'b1;
    seed2 = '0; seed3 = '0;
    seed_valid2 = 1'b0; seed_valid3 = 1'b0;
    reseed2 = 1'b0; reseed3 = 1'b0;
    rnd_ready2 = 1'b0; rnd_ready3 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_state", state2, 0);
    check("reset_valid", rnd_valid2, 0);
    check("reset_seed_ready", seed_ready2, 0);
    check("reset_busy", busy2, 0);
    check("reset_rnd", rnd2, 0);
    check("reset_state3", state3, 0);

    // d=2 seeding and warm-up from IDLE
    beat(2, 32'h0000_0001);
    beat(2, 32'h4000_0000);
    check("seed_ready_after_last", seed_ready2, 0);
    mdl[0] = fix31(32'h0000_0001);
    mdl[1] = fix31(32'h4000_0000);
    model_step(2, WARM2);
    warm_wait(2, WARM2);
    model_push(2, 30);
    consume(2, 10, 0);

    // backpressure: 5 stalled cycles then resume
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", rnd2, exp_q[0]);
      check("bp_valid", rnd_valid2, 1);
      @(negedge clk);
    end
    consume(2, 20, 1);
    check("q_empty_a", exp_q.size(), 0);

    // zero seed behaves as seed 1
    reseed2 = 1'b1;
    @(negedge clk);
    reseed2 = 1'b0;
    check("reseed_valid_low", rnd_valid2, 0);
    check("reseed_seed_ready", seed_ready2, 1);
    check("reseed_rnd_zero", rnd2, 0);
    beat(2, 32'h8000_0000);
    beat(2, 32'h0000_0001);
    mdl[0] = fix31(32'h8000_0000);
    mdl[1] = fix31(32'h0000_0001);
    model_step(2, WARM2);
    warm_wait(2, WARM2);
    model_push(2, 16);
    consume(2, 16, 1);

    // reset in the middle of RUN
    rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_valid", rnd_valid2, 0);
    check("midrun_rst_rnd", rnd2, 0);
    check("midrun_rst_seed_ready", seed_ready2, 0);
    check("midrun_rst_state", state2, 0);
    rst = 1'b0;

    // d=3: seed six lanes from IDLE
    for (int k = 0; k < 6; k++) begin
      seeds[k] = $urandom;
      beat(3, seeds[k]);
      mdl[k] = fix31(seeds[k]);
    end
    model_step(6, WARM3);
    warm_wait(3, WARM3);
    model_push(6, 8);
    consume(3, 3, 0);

    // reseed together with a handshake: that word is consumed
    reseed3 = 1'b1;
    rnd_ready3 = 1'b1;
    check("reseed_hs_word", rnd3, exp_q.pop_front());
    @(negedge clk);
    reseed3 = 1'b0;
    rnd_ready3 = 1'b0;
    exp_q.delete();
    check("reseed3_valid_low", rnd_valid3, 0);
    check("reseed3_seed_ready", seed_ready3, 1);
    check("reseed3_state", state3, 1);

    // throttled seeding with junk on the bus while seed_valid is low
    for (int k = 0; k < 6; k++) begin
      seeds[k] = (k == 2) ? 32'h8000_0000 : $urandom;
      beat(3, seeds[k]);
      mdl[k] = fix31(seeds[k]);
      if (k < 5) begin
        seed3 = 32'hdead_beef;
        check("throttle_seed_ready", seed_ready3, 1);
        @(negedge clk);
      end
    end
    check("seed_ready3_after_last", seed_ready3, 0);
    model_step(6, WARM3);
    warm_wait(3, WARM3);
    model_push(6, 12);
    consume(3, 12, 1);
    check("q_empty_b", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/msk_hpc3_rnd_feeder.md
# msk_hpc3_rnd_feeder

Fresh-randomness source for a column of HPC3 masked AND/Toffoli gadgets. It delivers `hpc3rnd` = d·(d−1) fresh bits per cycle on the gadget's `rnd` port. The bits come from `hpc3rnd` independent 31-bit LFSR lanes, seeded over a valid/ready beat interface. A valid/ready output handshake guarantees that no random word is ever presented twice, and a warm-up phase separates seeding from first use.

## Interface
- `d`, 2, number of shares; sets `hpc3rnd` = d·(d−1).
- `WARM`, 64, lane-advance cycles between the last seed beat and the first valid output; must be ≥ 1 and < 2^16.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `seed`  in  32  seed word for one lane; bits [30:0] are used and bit 31 is ignored.
- `seed_valid`  in  1  a seed word is present.
- `seed_ready`  out  1  high only in SEED.
- `reseed`  in  1  single-cycle request to re-enter SEED.
- `rnd`  out  hpc3rnd  random bits; bit k = output bit of lane k; forced to 0 whenever `rnd_valid` = 0.
- `rnd_valid`  out  1  `rnd` is fresh.
- `rnd_ready`  in  1  consumer takes `rnd` this cycle.
- `busy`  out  1  high in SEED or WARM.

## Operation
- Each lane is a 31-bit Fibonacci LFSR `s` with polynomial x^31+x^28+1.
  - Step: `s` ← {s[29:0], s[30]^s[27]}.
  - Lane output bit = s[30].
- States are IDLE, SEED, WARM and RUN. Reset enters IDLE.
  - In reset, all lane states, the lane index, the warm counter, `rnd_valid`, `seed_ready` and `busy` are 0.
- IDLE: no outputs are active. Asserting `reseed` or `seed_valid` moves to SEED on the next edge; a `seed_valid` in IDLE is not consumed.
- SEED:
  - `seed_ready` = 1.
  - Each beat with `seed_valid` & `seed_ready` loads lane[idx] ← seed[30:0], then idx ← idx+1.
  - An all-zero seed[30:0] is loaded as 31'h1, so a lane never locks up.
  - Accepting the beat for idx = hpc3rnd−1 resets idx to 0 and moves to WARM.
- WARM: every lane steps once per cycle and a 16-bit counter increments. After exactly WARM steps the block moves to RUN.
- RUN:
  - `rnd_valid` = 1.
  - Lanes step only on cycles where `rnd_valid` & `rnd_ready`.
  - While `rnd_ready` = 0, `rnd` is held unchanged.
- `reseed` in WARM or RUN moves to SEED on the next edge, with idx = 0 and the counter cleared.
  - `rnd_valid` is 0 from that edge onward.
  - A handshake that occurs in the same cycle as `reseed` completes normally.
- `reseed` while already in SEED restarts the load at idx = 0. Lanes that are already loaded are overwritten by the new beats.
- `rst` takes precedence over every input.

## Timing
- Seeding takes hpc3rnd accepted beats.
- The first `rnd_valid` = 1 appears exactly WARM cycles after the edge that accepts the last beat.
- After a handshake, the next word is available in the following cycle (zero bubble), for sustained throughput of 1 word/cycle.
- The consumer gadget registers `rnd` at the same edge as the handshake. The feeder must never let `rnd` change without a handshake while `rnd_valid` = 1.
- `busy`, `seed_ready` and `rnd_valid` are decoded from registered state only, with no combinational path from any input.

## Structure
- `hpc3rnd` comes from the shared HPC3 include (d·(d−1)). The shared package holds:
  - the state encoding;
  - the LFSR width (31) and taps (30, 27);
  - the seed-word width (32).
- One sub-module is natural: `msk_lfsr31_lane`. It has ports clk, load, load_val[30:0], step and out_bit, and contains the zero-seed fix-up. It is instantiated hpc3rnd times in a generate loop.
- The top level holds the FSM, the lane index and the warm counter.

## Test plan
- Reset mid-RUN with d=2 (2 lanes): assert `rst` for one cycle -> on the next cycle `rnd_valid` = 0, `rnd` = 0, `seed_ready` = 0, state IDLE.
- Seeding and warm-up, d=2, WARM=4: seeds 0x00000001 and 0x40000000 -> `rnd_valid` rises exactly 4 cycles after the second beat, and `rnd` matches a reference LFSR model stepped 4 times.
- Zero seed: seed 0x80000000 (bits [30:0] = 0) -> the lane loads 31'h1, and its output sequence is identical to that of seed 0x00000001.
- Backpressure: hold `rnd_ready` = 0 for 5 cycles in RUN -> `rnd` is stable for all 5 cycles; after `rnd_ready` rises, the words are the next model values in order, with none skipped or repeated.
- Reseed in RUN, d=3 (6 lanes): pulse `reseed` together with a handshake -> that word is consumed, `rnd_valid` = 0 on the next cycle, and `seed_ready` = 1 until 6 beats are accepted.
- Throttled seeding: toggle `seed_valid` 1/0 -> only beats with `seed_valid` & `seed_ready` load a lane, and idx advances by exactly the number of accepted beats.
